// File: rtl/mem_port_arbiter.sv
// Shares a single memory/cache port between instruction fetch (IF) and the
// data-memory stage (DM). One transaction in flight at a time; DM has priority,
// but IF is forced to win after MAX_STREAK consecutive DM grants while it waits.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch side
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    // data memory side
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    // shared port
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    // pipeline stall
    output logic              cache_busy_o
);

    localparam int unsigned STREAK_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;   // 1 = DM owns the transaction
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [STREAK_W-1:0]  streak_q, streak_d;

    logic arb_en;
    logic resp_done;
    logic streak_max;
    logic if_win;
    logic dm_win;
    logic grant;

    // Arbitration: open in IDLE or on the completing RESP cycle
    always_comb begin
        resp_done  = (state_q == RESP) && mem_rvalid_i;
        arb_en     = (state_q == IDLE) || resp_done;
        streak_max = (streak_q == STREAK_W'(MAX_STREAK));
        dm_win     = arb_en && dm_req_i && (!if_req_i || !streak_max);
        if_win     = arb_en && if_req_i && !dm_win;
        grant      = if_win || dm_win;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ISSUE;
            ISSUE:   if (mem_ready_i) state_d = RESP;
            RESP:    if (mem_rvalid_i) state_d = grant ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the winner's request and update the DM streak counter
    always_comb begin
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        streak_d = streak_q;
        if (grant) begin
            owner_d = dm_win;
            we_d    = dm_win && dm_we_i;
            addr_d  = dm_win ? dm_addr_i : if_addr_i;
            wdata_d = dm_win ? dm_wdata_i : '0;
        end
        if (!if_req_i || if_win) begin
            streak_d = '0;
        end else if (dm_win && !streak_max) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    // Transaction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            streak_q <= '0;
        end else begin
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            streak_q <= streak_d;
        end
    end

    // Output decode: port drive, grant pulses, response routing, stall
    always_comb begin
        if_gnt_o     = if_win;
        dm_gnt_o     = dm_win;
        mem_req_o    = (state_q == ISSUE);
        mem_we_o     = we_q;
        mem_addr_o   = addr_q;
        mem_wdata_o  = wdata_q;
        if_rvalid_o  = resp_done && !owner_q;
        dm_rvalid_o  = resp_done && owner_q;
        if_rdata_o   = if_rvalid_o ? mem_rdata_i : '0;
        dm_rdata_o   = dm_rvalid_o ? mem_rdata_i : '0;
        cache_busy_o = (if_req_i && !if_win) || (dm_req_i && !dm_win)
                     || ((state_q != IDLE) && !mem_rvalid_i);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against
// a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXS = 4;

    logic          clk, rst_n;
    logic          if_req, dm_req, dm_we, mem_ready, mem_rvalid;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata, mem_rdata;
    logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic          mem_req, mem_we, cache_busy;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int n_pass;
    int n_total;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .cache_busy_o(cache_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, cache_busy} !== 7'b0)
            $display("FAIL reset_flags got=%b exp=0",
                     {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, cache_busy});
        else n_pass++;
        n_total++;
        if ({mem_addr, mem_wdata} !== 64'h0)
            $display("FAIL reset_port got=%h/%h exp=0/0", mem_addr, mem_wdata);
        else n_pass++;
        nxt();
        rst_n = 1'b1;
        nxt();
    endtask

    task automatic test_if_fetch();
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        n_total++;
        if ({if_gnt, dm_gnt, mem_req} !== 3'b100)
            $display("FAIL fetch_gnt got=%b exp=100", {if_gnt, dm_gnt, mem_req});
        else n_pass++;
        nxt();
        if_req = 1'b0; if_addr = '0; mem_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if ({mem_req, mem_we, mem_addr, cache_busy, if_gnt} !== {1'b1, 1'b0, 32'h100, 1'b1, 1'b0})
            $display("FAIL fetch_issue got=%b/%b/%h/%b exp=1/0/100/1",
                     mem_req, mem_we, mem_addr, cache_busy);
        else n_pass++;
        nxt();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        n_total++;
        if ({if_rvalid, dm_rvalid, cache_busy} !== 3'b100 || if_rdata !== 32'hDEADBEEF)
            $display("FAIL fetch_resp got=%b/%h exp=100/deadbeef",
                     {if_rvalid, dm_rvalid, cache_busy}, if_rdata);
        else n_pass++;
        nxt();
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_store_wait();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h55;
        @(negedge clk);
        n_total++;
        if ({dm_gnt, if_gnt} !== 2'b10)
            $display("FAIL store_gnt got=%b exp=10", {dm_gnt, if_gnt});
        else n_pass++;
        nxt();
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'hFFFF; dm_wdata = 32'hAAAA;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_ready = 1'b1;
            @(negedge clk);
            n_total++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, if_rvalid, dm_rvalid}
                !== {1'b1, 1'b1, 32'h20, 32'h55, 1'b0, 1'b0})
                $display("FAIL store_hold%0d got=%b/%b/%h/%h exp=1/1/20/55",
                         k, mem_req, mem_we, mem_addr, mem_wdata);
            else n_pass++;
            nxt();
        end
        mem_ready = 1'b0; mem_rvalid = 1'b1;
        @(negedge clk);
        n_total++;
        if ({dm_rvalid, if_rvalid} !== 2'b10)
            $display("FAIL store_ack got=%b exp=10", {dm_rvalid, if_rvalid});
        else n_pass++;
        nxt();
        mem_rvalid = 1'b0;
    endtask

    // Both requesters busy, port answers at once; drop_at < 0 means never drop if_req.
    // A grant is expected on every even cycle; exp_if_at lists IF-grant cycles.
    task automatic run_contended(input string name, input int ncyc, input int drop_at,
                                 input int if_at0, input int if_at1);
        bit e_if, e_dm;
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; if_addr = 32'h200; dm_addr = 32'h40;
        mem_ready = 1'b1; mem_rvalid = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if_req = (c != drop_at);
            e_if = (c == if_at0) || (c == if_at1);
            e_dm = (c % 2 == 0) && !e_if;
            @(negedge clk);
            n_total++;
            if ({if_gnt, dm_gnt, mem_req} !== {e_if, e_dm, (c % 2 == 1)})
                $display("FAIL %s_c%0d got=%b exp=%b", name, c,
                         {if_gnt, dm_gnt, mem_req}, {e_if, e_dm, (c % 2 == 1)});
            else n_pass++;
            nxt();
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        n_total++;
        if ({if_rvalid, dm_rvalid} !== 2'b10)
            $display("FAIL %s_last_rv got=%b exp=10", name, {if_rvalid, dm_rvalid});
        else n_pass++;
        nxt();
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        nxt();
    endtask

    task automatic test_back_to_back();
        run_contended("streak", 20, -1, 8, 18);
    endtask

    task automatic test_streak_clear();
        run_contended("sclear", 16, 5, 14, 14);
    endtask

    task automatic test_spurious();
        mem_rvalid = 1'b1;
        @(negedge clk);
        n_total++;
        if ({if_rvalid, dm_rvalid, mem_req, cache_busy} !== 4'b0)
            $display("FAIL spur_idle got=%b exp=0000", {if_rvalid, dm_rvalid, mem_req, cache_busy});
        else n_pass++;
        nxt();
        mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h300;
        @(negedge clk);
        n_total++;
        if (if_gnt !== 1'b1) $display("FAIL spur_gnt got=%b exp=1", if_gnt);
        else n_pass++;
        nxt();
        if_req = 1'b0; mem_rvalid = 1'b1;
        @(negedge clk);
        n_total++;
        if ({if_rvalid, dm_rvalid, mem_req} !== 3'b001)
            $display("FAIL spur_issue got=%b exp=001", {if_rvalid, dm_rvalid, mem_req});
        else n_pass++;
        nxt();
        mem_rvalid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h300})
            $display("FAIL spur_still_issue got=%b/%h exp=1/300", mem_req, mem_addr);
        else n_pass++;
        nxt();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
        @(negedge clk);
        n_total++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h1234})
            $display("FAIL spur_resp got=%b/%h exp=1/1234", if_rvalid, if_rdata);
        else n_pass++;
        nxt();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        if_req = 1'b1; if_addr = 32'h400;
        nxt();
        if_req = 1'b0; mem_ready = 1'b1;
        nxt();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_rvalid = (k == 1);
            @(negedge clk);
            n_total++;
            if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, cache_busy,
                 mem_addr, if_rdata} !== '0)
                $display("FAIL rst_mid%0d got=%b/%h exp=0", k,
                         {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, cache_busy}, mem_addr);
            else n_pass++;
            nxt();
        end
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        @(negedge clk);
        n_total++;
        if ({if_rvalid, dm_rvalid, mem_req, cache_busy} !== 4'b0)
            $display("FAIL rst_stale got=%b exp=0000", {if_rvalid, dm_rvalid, mem_req, cache_busy});
        else n_pass++;
        nxt();
        mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h500;
        @(negedge clk);
        n_total++;
        if (if_gnt !== 1'b1) $display("FAIL rst_regnt got=%b exp=1", if_gnt);
        else n_pass++;
        nxt();
        if_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h500})
            $display("FAIL rst_reissue got=%b/%h exp=1/500", mem_req, mem_addr);
        else n_pass++;
        nxt();
        mem_ready = 1'b0; mem_rvalid = 1'b1;
        nxt();
        mem_rvalid = 1'b0;
    endtask

    // Random traffic against a transaction-level model
    task automatic test_random();
        bit          if_pend, dm_pend, busy, acc, own_dm, m_we;
        bit          e_ig, e_dg, e_irv, e_drv, e_req, e_busy, resp, can_arb;
        logic [AW-1:0] m_addr, p_if_addr, p_dm_addr;
        logic [DW-1:0] m_wdata, p_dm_wdata;
        bit          p_dm_we;
        int          streak;
        int          nrand;
        if_pend = 0; dm_pend = 0; busy = 0; acc = 0; own_dm = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; streak = 0; nrand = 400;
        p_if_addr = '0; p_dm_addr = '0; p_dm_wdata = '0; p_dm_we = 0;
        for (int c = 0; c < nrand + 10; c++) begin
            if (c < nrand) begin
                if (!if_pend && ($urandom_range(0, 1) == 1)) begin
                    if_pend = 1; p_if_addr = $urandom;
                end
                if (!dm_pend && ($urandom_range(0, 2) != 0)) begin
                    dm_pend = 1; p_dm_addr = $urandom; p_dm_wdata = $urandom;
                    p_dm_we = 1'($urandom_range(0, 1));
                end
                mem_ready  = 1'($urandom_range(0, 1));
                mem_rvalid = ($urandom_range(0, 2) == 0);
            end else begin
                mem_ready = 1'b1; mem_rvalid = 1'b1;
            end
            mem_rdata = $urandom;
            if_req = if_pend; if_addr = p_if_addr;
            dm_req = dm_pend; dm_addr = p_dm_addr; dm_wdata = p_dm_wdata; dm_we = p_dm_we;

            resp    = busy && acc && mem_rvalid;
            can_arb = !busy || resp;
            e_dg    = can_arb && dm_pend && !(if_pend && streak == int'(MAXS));
            e_ig    = can_arb && if_pend && !e_dg;
            e_irv   = resp && !own_dm;
            e_drv   = resp && own_dm;
            e_req   = busy && !acc;
            e_busy  = (if_pend && !e_ig) || (dm_pend && !e_dg) || (busy && !mem_rvalid);

            @(negedge clk);
            n_total++;
            if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, cache_busy}
                !== {e_ig, e_dg, e_irv, e_drv, e_req, e_busy})
                $display("FAIL rand_c%0d_flags got=%b exp=%b", c,
                         {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, cache_busy},
                         {e_ig, e_dg, e_irv, e_drv, e_req, e_busy});
            else n_pass++;
            if (e_req) begin
                n_total++;
                if ({mem_we, mem_addr} !== {m_we, m_addr} || (own_dm && mem_wdata !== m_wdata))
                    $display("FAIL rand_c%0d_port got=%b/%h/%h exp=%b/%h/%h", c,
                             mem_we, mem_addr, mem_wdata, m_we, m_addr, m_wdata);
                else n_pass++;
            end
            if (e_irv) begin
                n_total++;
                if (if_rdata !== mem_rdata)
                    $display("FAIL rand_c%0d_ird got=%h exp=%h", c, if_rdata, mem_rdata);
                else n_pass++;
            end
            if (e_drv && !m_we) begin
                n_total++;
                if (dm_rdata !== mem_rdata)
                    $display("FAIL rand_c%0d_drd got=%h exp=%h", c, dm_rdata, mem_rdata);
                else n_pass++;
            end

            if (resp) busy = 0;
            else if (busy && !acc && mem_ready) acc = 1;
            if (e_ig || e_dg) begin
                busy = 1; acc = 0; own_dm = e_dg;
                m_addr  = e_dg ? p_dm_addr : p_if_addr;
                m_we    = e_dg && p_dm_we;
                m_wdata = p_dm_wdata;
            end
            if (!if_pend || e_ig) streak = 0;
            else if (e_dg && streak < int'(MAXS)) streak++;
            if (e_ig) if_pend = 0;
            if (e_dg) dm_pend = 0;
            nxt();
        end
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        nxt();
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        test_reset();
        test_if_fetch();
        test_store_wait();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        test_streak_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
